// File: rtl/mpadder_limb.sv
// mpadder_limb: limb-serial multi-precision adder/subtracter with start/done handshake
module mpadder_limb #(
  parameter int WIDTH = 1027,
  parameter int LIMB  = 64
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic           done,
  output logic           busy
);
  localparam int NLIMBS = (WIDTH + LIMB) / LIMB;
  localparam int PW     = NLIMBS * LIMB;
  localparam int CW     = NLIMBS > 1 ? $clog2(NLIMBS) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t          state_q, state_d;
  logic [PW-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, limb_ext;
  logic [LIMB:0]   sum;
  logic            carry_q, carry_d, done_q, done_d, busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]  result_q, result_d;
  // Operands shift right one limb per cycle; sums enter the shadow accumulator from the top
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sum      = {1'b0, a_q[LIMB-1:0]} + {1'b0, b_q[LIMB-1:0]} + {{LIMB{1'b0}}, carry_q};
    limb_ext = PW'(sum[LIMB-1:0]) << (PW - LIMB);
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        a_d     = PW'(in_a);
        b_d     = subtract ? ~PW'(in_b) : PW'(in_b);
        carry_d = subtract;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    end else begin
      a_d     = a_q >> LIMB;
      b_d     = b_q >> LIMB;
      acc_d   = (acc_q >> LIMB) | limb_ext;
      carry_d = sum[LIMB];
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == CW'(NLIMBS - 1)) begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = acc_d[WIDTH:0];
      end
    end
  end
  // State registers with asynchronous abort to reset values
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_mpadder_limb.sv
// tb_mpadder_limb: table-driven and scoreboard checks for two adder configurations
module tb_mpadder_limb;
  typedef struct {
    logic          sub;
    logic [1026:0] a;
    logic [1026:0] b;
    logic [1027:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic s0 = 1'b0, sub0 = 1'b0, d0, bz0;
  logic [1026:0] a0 = '0, b0 = '0;
  logic [1027:0] r0;
  logic s1 = 1'b0, sub1 = 1'b0, d1, bz1;
  logic [7:0] a1 = '0, b1 = '0;
  logic [8:0] r1;
  logic [1027:0] q0[$];
  logic [1027:0] q1[$];
  int checks = 0;
  int errors = 0;
  vec_t v[0:11];
  logic [1027:0] prev;
  logic [1055:0] ra, rb;
  mpadder_limb #(.WIDTH(1027), .LIMB(64)) u_big (
    .clk(clk), .resetn(resetn), .start(s0), .subtract(sub0),
    .in_a(a0), .in_b(b0), .result(r0), .done(d0), .busy(bz0)
  );
  mpadder_limb #(.WIDTH(8), .LIMB(4)) u_small (
    .clk(clk), .resetn(resetn), .start(s1), .subtract(sub1),
    .in_a(a1), .in_b(b1), .result(r1), .done(d1), .busy(bz1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [1027:0] act, input logic [1027:0] exp);
    int fb = -1;
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < 1028; i++) if (fb < 0 && act[i] !== exp[i]) fb = i;
      $display("FAIL %s: got ...%h want ...%h (low 128 bits; top bit got %b want %b; first diff bit %0d)",
               nm, act[127:0], exp[127:0], act[1027], exp[1027], fb);
    end
  endtask
  // Scoreboards: compare each done against the oldest expected result
  always @(negedge clk) begin
    if (resetn && d0) begin
      if (q0.size() == 0) chk("sb0_unexpected_done", 1028'd1, 1028'd0);
      else chk("sb0_result", r0, q0.pop_front());
    end
    if (resetn && d1) begin
      if (q1.size() == 0) chk("sb1_unexpected_done", 1028'd1, 1028'd0);
      else chk("sb1_result", 1028'(r1), q1.pop_front());
    end
  end
  task automatic go0(input logic sub, input logic [1026:0] a, input logic [1026:0] b, input logic [1027:0] e);
    s0 = 1'b1; sub0 = sub; a0 = a; b0 = b;
    q0.push_back(e);
    @(posedge clk); #1;
    s0 = 1'b0; sub0 = ~sub; a0 = ~a; b0 = ~b;
  endtask
  task automatic wait0(input int lat, input int bexp);
    int n = 0;
    int bc = 0;
    while (!d0 && n < 40) begin
      bc += int'(bz0);
      @(posedge clk); #1;
      n++;
    end
    chk("lat0", 1028'(n), 1028'(lat));
    chk("busy0_cycles", 1028'(bc), 1028'(bexp));
  endtask
  task automatic go1(input logic sub, input logic [7:0] a, input logic [7:0] b, input logic [8:0] e);
    s1 = 1'b1; sub1 = sub; a1 = a; b1 = b;
    q1.push_back(1028'(e));
    @(posedge clk); #1;
    s1 = 1'b0; sub1 = ~sub; a1 = ~a; b1 = 8'($urandom);
  endtask
  task automatic wait1(input int lat, input int bexp);
    int n = 0;
    int bc = 0;
    while (!d1 && n < 20) begin
      bc += int'(bz1);
      @(posedge clk); #1;
      n++;
    end
    chk("lat1", 1028'(n), 1028'(lat));
    chk("busy1_cycles", 1028'(bc), 1028'(bexp));
  endtask
  task automatic done_low0;
    @(posedge clk); #1;
    chk("done0_width", 1028'(d0), 1028'd0);
  endtask
  task automatic done_low1;
    @(posedge clk); #1;
    chk("done1_width", 1028'(d1), 1028'd0);
  endtask
  initial begin
    v[0] = '{1'b0, 1027'd1, 1027'd1, 1028'd2};
    v[1] = '{1'b0, '1, '1, {{1027{1'b1}}, 1'b0}};
    v[2] = '{1'b1, '1, '1, 1028'd0};
    v[3] = '{1'b1, 1027'd1, 1027'd1, 1028'd0};
    v[4] = '{1'b1, 1027'd0, 1027'd1, {1028{1'b1}}};
    for (int i = 5; i < 12; i++) begin
      for (int w = 0; w < 33; w++) begin
        ra[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      v[i].sub = 1'($urandom_range(0, 1));
      v[i].a = ra[1026:0];
      v[i].b = rb[1026:0];
      v[i].exp = v[i].sub ? {1'b0, v[i].a} - {1'b0, v[i].b} : {1'b0, v[i].a} + {1'b0, v[i].b};
    end
    #12;
    chk("rst_result0", r0, 1028'd0);
    chk("rst_done0", 1028'(d0), 1028'd0);
    chk("rst_busy0", 1028'(bz0), 1028'd0);
    chk("rst_result1", 1028'(r1), 1028'd0);
    chk("rst_busy1", 1028'(bz1), 1028'd0);
    @(negedge clk); resetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      go0(v[i].sub, v[i].a, v[i].b, v[i].exp);
      wait0(17, 17);
      done_low0();
    end
    prev = v[11].exp;
    @(negedge clk);
    chk("hold_result0", r0, prev);
    go0(1'b0, 1027'd5, 1027'd7, 1028'd12);
    void'(q0.pop_back());
    repeat (5) @(posedge clk);
    #1;
    chk("hold_midrun0", r0, prev);
    resetn = 1'b0;
    #1;
    chk("abort_result0", r0, 1028'd0);
    chk("abort_done0", 1028'(d0), 1028'd0);
    chk("abort_busy0", 1028'(bz0), 1028'd0);
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    go0(1'b0, 1027'h123456789abcdef, 1027'hfedcba987654321, 1028'h1111111111111110);
    wait0(17, 17);
    done_low0();
    @(negedge clk);
    go1(1'b0, 8'hff, 8'h01, 9'h100);
    wait1(3, 3);
    done_low1();
    @(negedge clk);
    go1(1'b1, 8'h00, 8'hff, 9'h101);
    wait1(3, 3);
    done_low1();
    @(negedge clk);
    go1(1'b0, 8'h12, 8'h34, 9'h046);
    wait1(3, 3);
    go1(1'b1, 8'h10, 8'h20, 9'h1f0);
    wait1(3, 3);
    done_low1();
    @(negedge clk);
    go1(1'b0, 8'h80, 8'h80, 9'h100);
    s1 = 1'b1; sub1 = 1'b1; a1 = 8'h55; b1 = 8'h33;
    @(posedge clk); #1;
    s1 = 1'b0;
    wait1(2, 2);
    done_low1();
    repeat (4) @(posedge clk);
    #1;
    chk("idle_busy1", 1028'(bz1), 1028'd0);
    chk("sb0_drain", 1028'(q0.size()), 1028'd0);
    chk("sb1_drain", 1028'(q1.size()), 1028'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
